ins_fetch: RTL and testbench
============================

INS_FETCH -- requirements
Module: ins_fetch

Interface
REQ-001 SHALL have parameter: RESET_PC, 16'h0000, program counter value loaded on reset.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: fetch_en  input  1  permits starting a new instruction fetch.
REQ-005 SHALL have port: branch_valid  input  1  redirect request, sampled each posedge.
REQ-006 SHALL have port: branch_addr  input  16  redirect target.
REQ-007 SHALL have port: ROM_addr  output  16  registered address driven to instruction ROM.
REQ-008 SHALL have port: ROM_addr_out  input  16  address echo from ROM, tags ROM_InsSet_out.
REQ-009 SHALL have port: ROM_InsSet_out  input  16  ROM data, valid one posedge after ROM samples ROM_addr.
REQ-010 SHALL have port: out_valid  output  1  assembled instruction available.
REQ-011 SHALL have port: out_ready  input  1  decoder accepts instruction.
REQ-012 SHALL have port: out_word  output  16  first instruction word.
REQ-013 SHALL have port: out_imm  output  16  second word for two-word instructions, else 0.
REQ-014 SHALL have port: out_two_word  output  1  instruction is two words.
REQ-015 SHALL have port: out_pc  output  16  address of first word.

Function
REQ-016 SHALL use FSM states IDLE, W0, C0, W1, C1, OUT.
REQ-017 SHALL classify first word as two-word iff bits [13:12] == 2'b10; all other values are one-word.
REQ-018 IDLE: SHALL, if fetch_en, load ROM_addr <= pc and go to W0; else hold.
REQ-019 W0: SHALL go to C0 unconditionally, the ROM sampling ROM_addr at this edge.
REQ-020 C0: SHALL, if ROM_addr_out == pc, capture out_word <= ROM_InsSet_out and out_pc <= pc; else remain in C0 (stale data discarded).
REQ-021 C0 on match: SHALL, for a two-word instruction, load ROM_addr <= pc+1 (mod 2^16) and go to W1; else set out_imm <= 0, out_two_word <= 0, and go to OUT.
REQ-022 W1 -> C1 unconditionally; C1 SHALL capture out_imm when ROM_addr_out == pc+1 (mod 2^16), set out_two_word <= 1, and go to OUT; else remain in C1.
REQ-023 OUT: SHALL hold out_valid=1 with all out_* stable until out_ready.
REQ-024 On out_valid && out_ready: SHALL set pc <= pc + (out_two_word ? 2 : 1) mod 2^16 and drop out_valid next cycle.
REQ-025 After handshake: SHALL, if fetch_en, load ROM_addr <= new pc and go to W0; else go to IDLE.
REQ-026 Latency: one-word = 3 cycles fetch_en-accepting edge to out_valid; two-word = 5 cycles.
REQ-027 Deasserting fetch_en mid-fetch SHALL NOT abort; the current instruction completes to OUT.
REQ-028 branch_valid SHALL, in any state, set pc <= branch_addr, abort any in-flight fetch, clear out_valid, and go to W0 with ROM_addr <= branch_addr if fetch_en, else to IDLE.
REQ-029 branch_valid coincident with out_valid && out_ready: handshake SHALL count as completed and pc SHALL take branch_addr, not the increment.
REQ-030 Address arithmetic SHALL wrap modulo 2^16 (pc 16'hFFFF two-word: second word at 16'h0000, next pc 16'h0001).

Reset
REQ-031 rst_n low SHALL asynchronously set state IDLE, pc=RESET_PC, ROM_addr=RESET_PC, out_valid=0, out_word=0, out_imm=0, out_two_word=0, out_pc=0.
REQ-032 Reset asserted mid-fetch SHALL discard the in-flight instruction; the first fetch after release SHALL start at RESET_PC.

Verification
REQ-033 ROM[0]=16'b0001101101011100, fetch_en=1, out_ready=1 -> out_valid 3 cycles later, out_word=ROM[0], out_two_word=0, out_imm=0, out_pc=0; next ROM_addr=1.
REQ-034 pc=3, ROM[3]=16'b1010110111001100, ROM[4]=16'b1000010001001001 -> out_two_word=1, out_word=ROM[3], out_imm=ROM[4], out_pc=3; next pc=5.
REQ-035 out_ready=0 for 4 cycles while out_valid -> outputs stable, ROM_addr unchanged; pc advances only on the cycle after out_ready=1.
REQ-036 branch_valid with branch_addr=16'h0007 during C1 -> out_valid never asserted for the aborted instruction; next out_pc=7.
REQ-037 pc=16'hFFFF, two-word instruction -> imm read from 16'h0000, next pc=16'h0001.
REQ-038 rst_n pulsed low during W1 -> all outputs 0 immediately; after release, the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ins_fetch.sv
// Instruction fetch unit: walks a 16-bit PC through a tagged, one-cycle ROM,
// assembles one- or two-word instructions and hands them to the decoder.
module ins_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        branch_valid,
  input  logic [15:0] branch_addr,
  output logic [15:0] ROM_addr,
  input  logic [15:0] ROM_addr_out,
  input  logic [15:0] ROM_InsSet_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_word,
  output logic [15:0] out_imm,
  output logic        out_two_word,
  output logic [15:0] out_pc
);

  typedef enum logic [2:0] {IDLE, W0, C0, W1, C1, OUT} state_t;

  typedef struct packed {
    logic [15:0] word;
    logic [15:0] imm;
    logic        two_word;
    logic [15:0] pc;
  } ins_t;

  state_t      state, state_d;
  logic [15:0] pc, pc_d, rom_addr_d;
  logic [15:0] pc_inc1, pc_hs;
  ins_t        ins_q, ins_d;
  logic        is_two;

  assign pc_inc1 = pc + 16'd1;
  assign pc_hs   = ins_q.two_word ? pc + 16'd2 : pc_inc1;
  assign is_two  = (ROM_InsSet_out[13:12] == 2'b10);

  always_comb begin
    state_d    = state;
    pc_d       = pc;
    rom_addr_d = ROM_addr;
    ins_d      = ins_q;
    case (state)
      IDLE: if (fetch_en) begin
        rom_addr_d = pc;
        state_d    = W0;
      end
      W0: state_d = C0;
      // Data tagged with any other address is left over from an earlier request.
      C0: if (ROM_addr_out == pc) begin
        ins_d.word = ROM_InsSet_out;
        ins_d.pc   = pc;
        if (is_two) begin
          rom_addr_d = pc_inc1;
          state_d    = W1;
        end else begin
          ins_d.imm      = 16'h0000;
          ins_d.two_word = 1'b0;
          state_d        = OUT;
        end
      end
      W1: state_d = C1;
      C1: if (ROM_addr_out == pc_inc1) begin
        ins_d.imm      = ROM_InsSet_out;
        ins_d.two_word = 1'b1;
        state_d        = OUT;
      end
      OUT: if (out_ready) begin
        pc_d = pc_hs;
        if (fetch_en) begin
          rom_addr_d = pc_hs;
          state_d    = W0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Redirect overrides everything, including a same-cycle handshake increment.
    if (branch_valid) begin
      pc_d = branch_addr;
      if (fetch_en) begin
        rom_addr_d = branch_addr;
        state_d    = W0;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      ROM_addr <= RESET_PC;
      ins_q    <= '0;
    end else begin
      state    <= state_d;
      pc       <= pc_d;
      ROM_addr <= rom_addr_d;
      ins_q    <= ins_d;
    end
  end

  assign out_valid    = (state == OUT);
  assign out_word     = ins_q.word;
  assign out_imm      = ins_q.imm;
  assign out_two_word = ins_q.two_word;
  assign out_pc       = ins_q.pc;

endmodule

// File: tb/tb_ins_fetch.sv
// Bench for ins_fetch: tagged one-cycle ROM, PC-level reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_ins_fetch;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n, fetch_en, branch_valid, out_ready;
  logic [15:0] branch_addr;
  logic [15:0] ROM_addr;
  logic [15:0] rom_tag = 16'h5555;
  logic [15:0] rom_data = 16'h0000;
  logic        out_valid, out_two_word;
  logic [15:0] out_word, out_imm, out_pc;

  logic [15:0] mem [0:65535];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ins_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .branch_valid(branch_valid), .branch_addr(branch_addr),
    .ROM_addr(ROM_addr), .ROM_addr_out(rom_tag), .ROM_InsSet_out(rom_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_imm(out_imm), .out_two_word(out_two_word), .out_pc(out_pc)
  );

  // ROM: samples its address each edge, answers with data plus the address echo.
  always @(posedge clk) begin
    rom_tag  <= ROM_addr;
    rom_data <= mem[ROM_addr];
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the PC of the next instruction the decoder must see.
  logic [15:0] m_pc = RESET_PC;
  int          wd = 0;
  always @(negedge clk) begin
    logic [15:0] w, nxt, imm;
    logic        two;
    if (!rst_n) begin
      m_pc = RESET_PC;
      wd   = 0;
      chk("rst_valid", {15'd0, out_valid}, 16'd0);
      chk("rst_word", out_word, 16'd0);
      chk("rst_imm", out_imm, 16'd0);
      chk("rst_two", {15'd0, out_two_word}, 16'd0);
      chk("rst_pc", out_pc, 16'd0);
      chk("rst_rom_addr", ROM_addr, RESET_PC);
    end else begin
      w   = mem[m_pc];
      nxt = m_pc + 16'd1;
      two = (w[13:12] == 2'b10);
      imm = two ? mem[nxt] : 16'h0000;
      if (out_valid) begin
        wd = 0;
        chk("m_word", out_word, w);
        chk("m_two", {15'd0, out_two_word}, {15'd0, two});
        chk("m_imm", out_imm, imm);
        chk("m_pc", out_pc, m_pc);
      end else if (fetch_en && !branch_valid) begin
        wd++;
        if (wd > 6) begin
          chk("m_progress", 16'd0, 16'd1);
          wd = 0;
        end
      end else begin
        wd = 0;
      end
      if (branch_valid) m_pc = branch_addr;
      else if (out_valid && out_ready) m_pc = m_pc + (two ? 16'd2 : 16'd1);
    end
  end

  // Caller sits just after a posedge; returns just after the redirect edge.
  task automatic branch(input logic [15:0] a);
    branch_valid = 1'b1;
    branch_addr  = a;
    @(posedge clk); #1;
    branch_valid = 1'b0;
  endtask

  // Counts cycles (negedges) until out_valid, bounded.
  task automatic wait_valid(output int cnt);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cnt++;
      if (out_valid) break;
    end
    chk("valid_seen", {15'd0, out_valid}, 16'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int          n;
    logic [15:0] s_word, s_imm, s_pc, s_addr;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[16'h0000] = 16'b0001101101011100;
    mem[16'h0003] = 16'b1010110111001100;
    mem[16'h0004] = 16'b1000010001001001;
    mem[16'h0007] = 16'h1234;
    mem[16'hFFFF] = 16'h2000;
    rst_n = 1'b0; fetch_en = 1'b0; branch_valid = 1'b0;
    branch_addr = 16'h0000; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // One-word fetch from reset PC.
    @(posedge clk); #1 fetch_en = 1'b1;
    @(posedge clk); #1;
    wait_valid(n);
    chk("t1_latency", 16'(n), 16'd3);
    chk("t1_word", out_word, 16'h1B5C);
    chk("t1_two", {15'd0, out_two_word}, 16'd0);
    chk("t1_imm", out_imm, 16'h0000);
    chk("t1_pc", out_pc, 16'h0000);
    @(posedge clk); #1;
    chk("t1_next_addr", ROM_addr, 16'h0001);

    // Two-word fetch at pc=3, then a 4-cycle decoder stall.
    out_ready = 1'b0;
    branch(16'h0003);
    wait_valid(n);
    chk("t2_latency", 16'(n), 16'd5);
    chk("t2_word", out_word, 16'hADCC);
    chk("t2_imm", out_imm, 16'h8449);
    chk("t2_two", {15'd0, out_two_word}, 16'd1);
    chk("t2_pc", out_pc, 16'h0003);
    s_word = out_word; s_imm = out_imm; s_pc = out_pc; s_addr = ROM_addr;
    chk("t3_addr_hold", s_addr, 16'h0004);
    repeat (4) begin
      @(negedge clk);
      chk("t3_valid", {15'd0, out_valid}, 16'd1);
      chk("t3_word", out_word, s_word);
      chk("t3_imm", out_imm, s_imm);
      chk("t3_pc", out_pc, s_pc);
      chk("t3_addr", ROM_addr, s_addr);
    end
    @(posedge clk); #1;
    chk("t3_addr_pre", ROM_addr, s_addr);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t3_next_addr", ROM_addr, 16'h0005);
    chk("t3_valid_drop", {15'd0, out_valid}, 16'd0);

    // Redirect while waiting on the second word.
    branch(16'h0003);
    repeat (3) @(posedge clk);
    #1 chk("t4_in_c1_addr", ROM_addr, 16'h0004);
    branch(16'h0007);
    wait_valid(n);
    chk("t4_latency", 16'(n), 16'd3);
    chk("t4_pc", out_pc, 16'h0007);
    chk("t4_word", out_word, 16'h1234);

    // Wraparound: two-word at 16'hFFFF.
    branch(16'hFFFF);
    wait_valid(n);
    chk("t5_latency", 16'(n), 16'd5);
    chk("t5_word", out_word, 16'h2000);
    chk("t5_imm", out_imm, 16'h1B5C);
    chk("t5_two", {15'd0, out_two_word}, 16'd1);
    chk("t5_pc", out_pc, 16'hFFFF);
    @(posedge clk); #1;
    chk("t5_next_addr", ROM_addr, 16'h0001);

    // Reset during the second-word wait.
    branch(16'h0003);
    @(posedge clk); @(posedge clk); #1;
    chk("t6_in_w1_addr", ROM_addr, 16'h0004);
    rst_n = 1'b0;
    #1;
    chk("t6_valid", {15'd0, out_valid}, 16'd0);
    chk("t6_word", out_word, 16'h0000);
    chk("t6_imm", out_imm, 16'h0000);
    chk("t6_two", {15'd0, out_two_word}, 16'd0);
    chk("t6_pc", out_pc, 16'h0000);
    chk("t6_addr", ROM_addr, RESET_PC);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    wait_valid(n);
    chk("t6_latency", 16'(n), 16'd3);
    chk("t6_restart_pc", out_pc, RESET_PC);
    chk("t6_restart_word", out_word, 16'h1B5C);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      fetch_en     = ($urandom_range(0, 3) != 0);
      out_ready    = ($urandom_range(0, 2) != 0);
      branch_valid = ($urandom_range(0, 19) == 0);
      branch_addr  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFFC, 16'hFFFF))
                                                 : 16'($urandom_range(0, 63));
    end
    @(posedge clk); #1 branch_valid = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
